// File: rtl/branch_predictor_gen2_if.sv
// Fetch/decode-side bundle for branch_predictor_gen2: lookup PC, decode-stage training
// signals and the prediction outputs.
interface branch_predictor_gen2_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned CTR_W  = 2
);
  logic              enable;
  logic [ADDR_W-1:0] PC_curr;
  logic [ADDR_W-1:0] IF_ID_PC_curr;
  logic [CTR_W-1:0]  IF_ID_prediction;
  logic [IDX_W-1:0]  IF_ID_ghr;
  logic              was_branch;
  logic              actual_taken;
  logic [ADDR_W-1:0] actual_target;
  logic              branch_mispredicted;
  logic [CTR_W-1:0]  prediction;
  logic [ADDR_W-1:0] predicted_target;
  logic              btb_hit;
  logic              predict_taken;
  logic [IDX_W-1:0]  ghr;

  modport master (
    output enable, PC_curr, IF_ID_PC_curr, IF_ID_prediction, IF_ID_ghr, was_branch,
           actual_taken, actual_target, branch_mispredicted,
    input  prediction, predicted_target, btb_hit, predict_taken, ghr
  );

  modport slave (
    input  enable, PC_curr, IF_ID_PC_curr, IF_ID_prediction, IF_ID_ghr, was_branch,
           actual_taken, actual_target, branch_mispredicted,
    output prediction, predicted_target, btb_hit, predict_taken, ghr
  );
endinterface

// File: rtl/branch_predictor_gen2.sv
// Saturating-counter BHT plus tagged, valid-qualified BTB with combinational lookup.
// Define BP_GSHARE_EN to add a global history register that is XORed into the BHT index.
module branch_predictor_gen2 #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned CTR_W  = 2
) (
  input logic                   clk,
  input logic                   rst,
  branch_predictor_gen2_if.slave bp
);
  localparam int unsigned Depth = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CtrWeakNt = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CtrWeakT  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CtrMax    = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CtrOne    = {{(CTR_W-1){1'b0}}, 1'b1};

  logic [CTR_W-1:0]  bht_q [Depth];
  logic [TAG_W-1:0]  tag_q [Depth];
  logic [ADDR_W-1:0] tgt_q [Depth];
  logic [Depth-1:0]  valid_q;

  logic [IDX_W-1:0] f_idx, f_bidx, u_idx, u_bidx, ghr_cur;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit, upd;
  logic [CTR_W-1:0] f_ctr, u_ctr, u_ctr_inc, u_ctr_dec;

  assign f_idx = bp.PC_curr[IDX_W:1];
  assign f_tag = bp.PC_curr[IDX_W+TAG_W:IDX_W+1];
  assign u_idx = bp.IF_ID_PC_curr[IDX_W:1];
  assign u_tag = bp.IF_ID_PC_curr[IDX_W+TAG_W:IDX_W+1];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  assign ghr_cur = ghr_q;
  assign f_bidx  = f_idx ^ ghr_q;
  assign u_bidx  = u_idx ^ bp.IF_ID_ghr;

  // Mispredict repair takes priority over the speculative shift of a fetch hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr_q <= '0;
    end else if (bp.enable) begin
      if (bp.branch_mispredicted) begin
        ghr_q <= {bp.IF_ID_ghr[IDX_W-2:0], bp.actual_taken};
      end else if (f_hit) begin
        ghr_q <= {ghr_q[IDX_W-2:0], bp.predict_taken};
      end
    end
  end

  logic unused_sig;
  assign unused_sig = ^{bp.IF_ID_prediction, bp.PC_curr, bp.IF_ID_PC_curr};
`else
  assign ghr_cur = '0;
  assign f_bidx  = f_idx;
  assign u_bidx  = u_idx;

  logic unused_sig;
  assign unused_sig = ^{bp.IF_ID_prediction, bp.PC_curr, bp.IF_ID_PC_curr, bp.IF_ID_ghr,
                        bp.branch_mispredicted};
`endif

  // Lookup: combinational on current table contents, no bypass from a same-cycle write.
  always_comb begin
    f_ctr = bht_q[f_bidx];
    f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  end

  assign bp.prediction       = f_ctr;
  assign bp.btb_hit          = f_hit;
  assign bp.predicted_target = f_hit ? tgt_q[f_idx] : '0;
  assign bp.predict_taken    = f_hit & f_ctr[CTR_W-1];
  assign bp.ghr              = ghr_cur;

  always_comb begin
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_ctr     = bht_q[u_bidx];
    u_ctr_inc = (u_ctr == CtrMax) ? u_ctr : u_ctr + CtrOne;
    u_ctr_dec = (u_ctr == '0) ? u_ctr : u_ctr - CtrOne;
    upd       = bp.enable & bp.was_branch;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        bht_q[i] <= CtrWeakNt;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (upd) begin
      if (u_hit) begin
        if (bp.actual_taken) begin
          bht_q[u_bidx] <= u_ctr_inc;
          tgt_q[u_idx]  <= bp.actual_target;
        end else begin
          bht_q[u_bidx] <= u_ctr_dec;
        end
      end else if (bp.actual_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= bp.actual_target;
        bht_q[u_bidx]  <= CtrWeakT;
      end
    end
  end

endmodule
